ii_read_arbiter: RTL and testbench

II_READ_ARBITER -- requirements
Module: ii_read_arbiter

---
 rtl/ii_read_arbiter_pkg.sv | 14 +
 rtl/ii_rd_pipe.sv | 59 +++++
 rtl/ii_read_arbiter.sv | 94 +++++++++
 tb/tb_ii_read_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ii_read_arbiter_pkg.sv
// Shared face-detector constants and the integral-image read arbiter's swap FSM encoding.
package ii_read_arbiter_pkg;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 20;
  localparam int TAG_W     = 2;
  localparam int II_WIDTH  = 160;
  localparam int II_HEIGHT = 120;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } swap_state_t;
endpackage

// File: rtl/ii_rd_pipe.sv
// Owner/tag delay line matching BRAM latency, plus the registered display/detector return ports.
module ii_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int DATA_W = 20,
  parameter int TAG_W  = 2
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              issue,
  input  logic              issue_det,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] bram_rddata,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              det_rvalid,
  output logic [DATA_W-1:0] det_rdata,
  output logic [TAG_W-1:0]  det_rtag
);
  logic [RD_LAT-1:0]            vld_pipe;
  logic [RD_LAT-1:0]            det_pipe;
  logic [RD_LAT-1:0][TAG_W-1:0] tag_pipe;
  logic                         out_det, out_disp;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vld_pipe <= '0;
      det_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      det_pipe[0] <= issue_det;
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        det_pipe[i] <= det_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Last stage lines up with bram_rddata for the address issued RD_LAT cycles ago.
  assign out_det  = vld_pipe[RD_LAT-1] &  det_pipe[RD_LAT-1];
  assign out_disp = vld_pipe[RD_LAT-1] & ~det_pipe[RD_LAT-1];

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      disp_rdata <= '0;
      det_rvalid <= 1'b0;
      det_rdata  <= '0;
      det_rtag   <= '0;
    end else begin
      det_rvalid <= out_det;
      if (out_det) begin
        det_rdata <= bram_rddata;
        det_rtag  <= tag_pipe[RD_LAT-1];
      end
      if (out_disp) disp_rdata <= bram_rddata;
    end
  end
endmodule

// File: rtl/ii_read_arbiter.sv
// Display-priority BRAM read arbiter with double-buffered integral-image bank swap at vsync.
module ii_read_arbiter
  import ii_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = ii_read_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ii_read_arbiter_pkg::DATA_W,
  parameter int TAG_W  = ii_read_arbiter_pkg::TAG_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              vsync,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  input  logic [TAG_W-1:0]  det_tag,
  output logic              det_gnt,
  output logic              det_rvalid,
  output logic [DATA_W-1:0] det_rdata,
  output logic [TAG_W-1:0]  det_rtag,
  input  logic              frame_ready,
  output logic              bank_sel,
  output logic              wr_bank,
  output logic              det_frame_start,
  output logic [ADDR_W:0]   bram_addr,
  input  logic [DATA_W-1:0] bram_rddata
);
  localparam int CNT_W = $clog2(RD_LAT + 2);

  swap_state_t      state;
  logic             vsync_q, vsync_fall, swap_block;
  logic [CNT_W-1:0] inflight;

  assign swap_block = (state == DRAIN);
  assign det_gnt    = det_req & ~disp_active & ~rst & ~swap_block;
  assign wr_bank    = ~bank_sel;
  assign bram_addr  = {bank_sel, disp_active ? disp_addr : det_addr};
  assign vsync_fall = vsync_q & ~vsync;

  // Only detector reads are counted; display reads never straddle a swap since vsync is low.
  always_ff @(posedge clk_vga) begin
    if (rst) inflight <= '0;
    else begin
      case ({det_gnt, det_rvalid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state           <= RUN;
      bank_sel        <= 1'b0;
      det_frame_start <= 1'b0;
      vsync_q         <= 1'b1;
    end else begin
      vsync_q         <= vsync;
      det_frame_start <= 1'b0;
      case (state)
        RUN:     if (frame_ready) state <= vsync_fall ? DRAIN : PENDING;
        PENDING: if (vsync_fall) state <= DRAIN;
        DRAIN: begin
          if (inflight == '0) begin
            bank_sel        <= ~bank_sel;
            det_frame_start <= 1'b1;
            state           <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  ii_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_rd_pipe (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .issue       (disp_active | det_gnt),
    .issue_det   (~disp_active),
    .issue_tag   (det_tag),
    .bram_rddata (bram_rddata),
    .disp_rdata  (disp_rdata),
    .det_rvalid  (det_rvalid),
    .det_rdata   (det_rdata),
    .det_rtag    (det_rtag)
  );
endmodule

// File: tb/tb_ii_read_arbiter.sv
// Scoreboard bench: driver predicts grants/addresses and queues returns; monitor checks return ports.
module tb_ii_read_arbiter;
  localparam int AW = 15;
  localparam int DW = 20;
  localparam int TW = 2;

  logic          clk_vga = 1'b0;
  logic          rst = 1'b1, vsync = 1'b1, disp_active = 1'b0, det_req = 1'b0, frame_ready = 1'b0;
  logic [AW-1:0] disp_addr = '0, det_addr = '0;
  logic [TW-1:0] det_tag = '0;
  logic [DW-1:0] disp_rdata, det_rdata, bram_rddata;
  logic          det_gnt, det_rvalid, bank_sel, wr_bank, det_frame_start;
  logic [TW-1:0] det_rtag;
  logic [AW:0]   bram_addr;

  ii_read_arbiter dut (
    .clk_vga(clk_vga), .rst(rst), .vsync(vsync),
    .disp_active(disp_active), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .det_req(det_req), .det_addr(det_addr), .det_tag(det_tag), .det_gnt(det_gnt),
    .det_rvalid(det_rvalid), .det_rdata(det_rdata), .det_rtag(det_rtag),
    .frame_ready(frame_ready), .bank_sel(bank_sel), .wr_bank(wr_bank),
    .det_frame_start(det_frame_start), .bram_addr(bram_addr), .bram_rddata(bram_rddata)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic logic [DW-1:0] mem(input logic [AW:0] a);
    logic [31:0] t;
    t = {16'b0, a} * 32'd40503 + 32'd7;
    return t[DW-1:0];
  endfunction

  // BRAM with one cycle of read latency
  always @(posedge clk_vga) bram_rddata <= mem(bram_addr);

  typedef struct { int due; logic [DW-1:0] data; logic [TW-1:0] tag; } ret_t;
  ret_t det_q[$], disp_q[$];
  int   det_dues[$];

  int nchk = 0, npass = 0, cyc = 0, rst_at = -1;
  bit run_chk = 0;
  logic [DW-1:0] e_disp = '0;
  bit m_bank = 0, m_pend = 0, m_drain = 0, m_vs_prev = 1, m_fs = 0;
  int grants = 0, max_inf = 0;

  always @(posedge clk_vga) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: return ports against the scoreboard queues
  always @(negedge clk_vga) if (run_chk) begin
    ret_t e;
    if (rst_at == cyc) e_disp = '0;
    while (disp_q.size() > 0 && disp_q[0].due < cyc) begin
      e = disp_q.pop_front(); chk("disp_missed", 1, 0);
    end
    if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
      e = disp_q.pop_front(); e_disp = e.data;
    end
    chk("disp_rdata", 32'(disp_rdata), 32'(e_disp));
    while (det_q.size() > 0 && det_q[0].due < cyc) begin
      e = det_q.pop_front(); chk("det_missed", 1, 0);
    end
    if (det_q.size() > 0 && det_q[0].due == cyc) begin
      e = det_q.pop_front();
      chk("det_rvalid", 32'(det_rvalid), 1);
      chk("det_rdata", 32'(det_rdata), 32'(e.data));
      chk("det_rtag", 32'(det_rtag), 32'(e.tag));
    end else chk("det_rvalid_idle", 32'(det_rvalid), 0);
  end

  // One clock cycle of stimulus plus the reference model's view of that cycle
  task automatic step(input logic r, input logic vs, input logic da, input logic [AW-1:0] daa,
                      input logic dr, input logic [AW-1:0] dta, input logic [TW-1:0] tg,
                      input logic fr);
    bit e_gnt, fall;
    int cnt;
    ret_t x;
    @(negedge clk_vga);
    chk("bank_sel", 32'(bank_sel), 32'(m_bank));
    chk("wr_bank", 32'(wr_bank), 32'(!m_bank));
    chk("det_frame_start", 32'(det_frame_start), 32'(m_fs));
    rst = r; vsync = vs; disp_active = da; disp_addr = daa;
    det_req = dr; det_addr = dta; det_tag = tg; frame_ready = fr;
    #1;
    while (det_dues.size() > 0 && det_dues[0] < cyc) void'(det_dues.pop_front());
    cnt = det_dues.size();
    chk("inflight", 32'(dut.inflight), cnt);
    if (int'(dut.inflight) > max_inf) max_inf = int'(dut.inflight);
    e_gnt = dr && !da && !r && !m_drain;
    chk("det_gnt", 32'(det_gnt), 32'(e_gnt));
    if (det_gnt === 1'b1) grants++;
    if (da) chk("bram_addr_disp", 32'(bram_addr), 32'({m_bank, daa}));
    else if (dr) chk("bram_addr_det", 32'(bram_addr), 32'({m_bank, dta}));
    if (!r) begin
      if (da) begin
        x.due = cyc + 2; x.data = mem({m_bank, daa}); x.tag = '0; disp_q.push_back(x);
      end else if (e_gnt) begin
        x.due = cyc + 2; x.data = mem({m_bank, dta}); x.tag = tg; det_q.push_back(x);
        det_dues.push_back(cyc + 2);
      end
    end
    fall = m_vs_prev && !vs;
    m_fs = 0;
    if (r) begin
      m_bank = 0; m_pend = 0; m_drain = 0; m_vs_prev = 1;
      while (det_q.size() > 0 && det_q[$].due > cyc) void'(det_q.pop_back());
      while (disp_q.size() > 0 && disp_q[$].due > cyc) void'(disp_q.pop_back());
      det_dues.delete();
      rst_at = cyc + 1;
    end else begin
      m_vs_prev = vs;
      if (m_drain) begin
        if (cnt == 0) begin m_bank = !m_bank; m_fs = 1; m_drain = 0; end
      end else if (m_pend) begin
        if (fall) begin m_pend = 0; m_drain = 1; end
      end else if (fr) begin
        if (fall) m_drain = 1; else m_pend = 1;
      end
    end
  endtask

  task automatic idle(input logic vs, input int n);
    for (int i = 0; i < n; i++) step(0, vs, 0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    logic r, vs, da, dr, fr;
    repeat (2) @(posedge clk_vga);
    run_chk = 1;
    step(1, 1, 0, '0, 0, '0, '0, 0);           // reset state
    // display wins over detector
    step(0, 1, 1, 15'h0005, 1, 15'h0777, 2'd1, 0);
    idle(1, 3);
    // lone detector read
    step(0, 1, 0, '0, 1, 15'h1234, 2'd2, 0);
    idle(1, 3);
    // frame_ready, then vsync fall with detector reads in flight
    step(0, 1, 0, '0, 0, '0, '0, 1);
    step(0, 1, 0, '0, 1, 15'h0100, 2'd3, 0);
    step(0, 0, 0, '0, 1, 15'h0101, 2'd0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1, 15'(16'h0200 + i), 2'(i), 0);
    idle(1, 2);
    // reset the cycle after a grant
    step(0, 1, 0, '0, 1, 15'h0333, 2'd1, 0);
    step(1, 1, 0, '0, 0, '0, '0, 0);
    idle(1, 3);
    chk("bank_after_rst", 32'(bank_sel), 0);
    // frame_ready coincident with vsync fall
    step(0, 0, 0, '0, 0, '0, '0, 1);
    idle(0, 1);
    step(0, 0, 0, '0, 1, 15'h0042, 2'd1, 0);
    chk("swap_bank15", 32'(bram_addr[AW]), 1);
    idle(0, 3);
    // 100 back-to-back detector reads in blanking
    grants = 0; max_inf = 0;
    for (int i = 0; i < 100; i++) step(0, 0, 0, '0, 1, 15'($urandom), 2'($urandom), 0);
    idle(0, 3);
    chk("grants100", grants, 100);
    chk("inflight_max_le2", 32'(max_inf <= 2), 1);
    // randomized mix
    vs = 1;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) vs = !vs;
      da = ($urandom_range(2) == 0);
      dr = ($urandom_range(1) == 0);
      fr = ($urandom_range(15) == 0);
      step(r, vs, da, 15'($urandom), dr, 15'($urandom), 2'($urandom), fr);
    end
    idle(1, 6);
    chk("det_q_empty", det_q.size(), 0);
    chk("disp_q_empty", disp_q.size(), 0);
    @(negedge clk_vga);
    run_chk = 0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
